// File: rtl/uart_rx_framer.sv
// -----------------------------------------------------------------------------
// uart_rx_framer
//
// Purpose:
//   Sits behind a UART receiver and turns its byte stream into framed packets.
//   Frame layout on the wire:  SYNC, LEN, LEN payload bytes, CHK
//   where CHK = (LEN + sum of payload bytes) mod 2^D_BITS.
//   Payload bytes are streamed out with start/last markers, and the frame is
//   closed with either a frame_ok pulse or a frame_err pulse plus an error code.
//   An inter-byte timeout aborts a frame that stalls, and a saturating counter
//   keeps a tally of aborted frames.
//
// Ports:
//   i_clk        in   1       system clock (only clock in the block)
//   reset        in   1       synchronous, active-high reset
//   rx_data      in   D_BITS  byte from the UART receiver, valid with rx_dvalid
//   rx_dvalid    in   1       one-cycle strobe per received byte
//   o_data       out  D_BITS  payload byte (driven to zero when o_dvalid is low)
//   o_dvalid     out  1       one-cycle strobe per payload byte
//   o_sof        out  1       with o_dvalid: first payload byte of the frame
//   o_last       out  1       with o_dvalid: last payload byte of the frame
//   o_frame_ok   out  1       one-cycle pulse: checksum matched
//   o_frame_err  out  1       one-cycle pulse: frame aborted
//   o_err_code   out  2       with o_frame_err: 01 bad LEN, 10 bad CHK, 11 timeout
//   o_busy       out  1       high while a frame is in progress
//   o_err_cnt    out  16      number of o_frame_err pulses, saturating
//
// Every output is a register; a response shows up the cycle after the
// rx_dvalid strobe that caused it.
// -----------------------------------------------------------------------------
module uart_rx_framer #(
    parameter int                D_BITS       = 8,
    parameter logic [D_BITS-1:0] SYNC_BYTE    = 8'hAA,
    parameter int                MAX_LEN      = 64,
    parameter int                TIMEOUT_CLKS = 100_000
) (
    input  logic              i_clk,
    input  logic              reset,
    input  logic [D_BITS-1:0] rx_data,
    input  logic              rx_dvalid,
    output logic [D_BITS-1:0] o_data,
    output logic              o_dvalid,
    output logic              o_sof,
    output logic              o_last,
    output logic              o_frame_ok,
    output logic              o_frame_err,
    output logic [1:0]        o_err_code,
    output logic              o_busy,
    output logic [15:0]       o_err_cnt
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    // The timeout counter only ever needs to hold TIMEOUT_CLKS-1: the abort is
    // decided on the cycle it would have stepped to TIMEOUT_CLKS.
    localparam int TO_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);
    localparam logic [D_BITS-1:0] MAX_LEN_V = D_BITS'(MAX_LEN);
    localparam logic [D_BITS-1:0] BYTE_ONE  = D_BITS'(1);

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CHK  = 2'b10;
    localparam logic [1:0] ERR_TO   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHK     = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t            state_reg,   state_next;
    logic [D_BITS-1:0] remain_reg,  remain_next;   // payload bytes still due
    logic [D_BITS-1:0] sum_reg,     sum_next;      // running checksum
    logic              first_reg,   first_next;    // next payload byte is first
    logic [TO_W-1:0]   to_cnt_reg,  to_cnt_next;   // idle cycles since last byte

    // Registered outputs
    logic [D_BITS-1:0] data_reg,    data_next;
    logic              dvalid_reg,  dvalid_next;
    logic              sof_reg,     sof_next;
    logic              last_reg,    last_next;
    logic              ok_reg,      ok_next;
    logic              err_reg,     err_next;
    logic [1:0]        code_reg,    code_next;
    logic [15:0]       err_cnt_reg, err_cnt_next;

    // -------------------------------------------------------------------------
    // Byte classification
    // -------------------------------------------------------------------------
    // Bitwise SYNC comparison, reduced to a single match flag.
    logic [D_BITS-1:0] sync_bit_match;

    for (genvar gi = 0; gi < D_BITS; gi++) begin : g_sync_match
        assign sync_bit_match[gi] = ~(rx_data[gi] ^ SYNC_BYTE[gi]);
    end

    logic is_sync;
    logic len_bad;
    logic chk_match;
    logic busy;
    logic timeout_hit;

    assign is_sync   = &sync_bit_match;
    assign len_bad   = (rx_data == '0) || (rx_data > MAX_LEN_V);
    assign chk_match = (rx_data == sum_reg);
    assign busy      = (state_reg != ST_IDLE);

    // A byte arriving on the very cycle the timeout would fire takes priority:
    // the timeout is only declared on a cycle without rx_dvalid.
    assign timeout_hit = busy && !rx_dvalid && (to_cnt_reg == TO_LAST);

    // -------------------------------------------------------------------------
    // Process 1: state register (and all other registers)
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            remain_reg  <= '0;
            sum_reg     <= '0;
            first_reg   <= 1'b0;
            to_cnt_reg  <= '0;
            data_reg    <= '0;
            dvalid_reg  <= 1'b0;
            sof_reg     <= 1'b0;
            last_reg    <= 1'b0;
            ok_reg      <= 1'b0;
            err_reg     <= 1'b0;
            code_reg    <= ERR_NONE;
            err_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            remain_reg  <= remain_next;
            sum_reg     <= sum_next;
            first_reg   <= first_next;
            to_cnt_reg  <= to_cnt_next;
            data_reg    <= data_next;
            dvalid_reg  <= dvalid_next;
            sof_reg     <= sof_next;
            last_reg    <= last_next;
            ok_reg      <= ok_next;
            err_reg     <= err_next;
            code_reg    <= code_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Process 2: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                // Sync hunt: anything other than SYNC is dropped.
                if (rx_dvalid && is_sync) begin
                    state_next = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_dvalid) begin
                    state_next = len_bad ? ST_IDLE : ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                // SYNC-valued bytes are ordinary data here.
                if (rx_dvalid && (remain_reg == BYTE_ONE)) begin
                    state_next = ST_CHK;
                end
            end
            ST_CHK: begin
                // Returning to IDLE on the CHK edge lets a SYNC on the very
                // next cycle start the following frame.
                if (rx_dvalid) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (timeout_hit) begin
            state_next = ST_IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // Process 3: output and datapath next values
    // -------------------------------------------------------------------------
    always_comb begin
        data_next   = '0;
        dvalid_next = 1'b0;
        sof_next    = 1'b0;
        last_next   = 1'b0;
        ok_next     = 1'b0;
        err_next    = 1'b0;
        code_next   = ERR_NONE;
        remain_next = remain_reg;
        sum_next    = sum_reg;
        first_next  = first_reg;

        // Idle counter: held at zero outside a frame and on every byte.
        if (!busy || rx_dvalid || timeout_hit) begin
            to_cnt_next = '0;
        end else begin
            to_cnt_next = to_cnt_reg + TO_ONE;
        end

        if (rx_dvalid) begin
            unique case (state_reg)
                ST_IDLE: begin
                    // Nothing to emit while hunting.
                end
                ST_LEN: begin
                    if (len_bad) begin
                        err_next  = 1'b1;
                        code_next = ERR_LEN;
                    end else begin
                        // LEN itself is part of the checksum.
                        remain_next = rx_data;
                        sum_next    = rx_data;
                        first_next  = 1'b1;
                    end
                end
                ST_PAYLOAD: begin
                    data_next   = rx_data;
                    dvalid_next = 1'b1;
                    sof_next    = first_reg;
                    last_next   = (remain_reg == BYTE_ONE);
                    sum_next    = sum_reg + rx_data;
                    remain_next = remain_reg - BYTE_ONE;
                    first_next  = 1'b0;
                end
                ST_CHK: begin
                    if (chk_match) begin
                        ok_next = 1'b1;
                    end else begin
                        err_next  = 1'b1;
                        code_next = ERR_CHK;
                    end
                end
                default: begin
                end
            endcase
        end else if (timeout_hit) begin
            err_next  = 1'b1;
            code_next = ERR_TO;
        end

        // The tally includes the pulse being issued this edge; it sticks at
        // all-ones instead of wrapping.
        if (err_next && (err_cnt_reg != 16'hFFFF)) begin
            err_cnt_next = err_cnt_reg + 16'd1;
        end else begin
            err_cnt_next = err_cnt_reg;
        end
    end

    // -------------------------------------------------------------------------
    // Output mapping
    // -------------------------------------------------------------------------
    assign o_data      = data_reg;
    assign o_dvalid    = dvalid_reg;
    assign o_sof       = sof_reg;
    assign o_last      = last_reg;
    assign o_frame_ok  = ok_reg;
    assign o_frame_err = err_reg;
    assign o_err_code  = code_reg;
    assign o_busy      = busy;
    assign o_err_cnt   = err_cnt_reg;

endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
- Sits directly downstream of the UART receiver; consumes its byte stream (rx_data / rx_dvalid) and extracts framed packets.
- Frame format: SYNC, LEN, LEN payload bytes, CHK.
- Streams payload bytes to the application layer with start/last markers, then reports frame pass/fail.
- Owns frame-level error detection and an inter-byte timeout; keeps a saturating error counter.

Parameters:
- D_BITS, 8, byte width; must match the receiver's D_BITS.
- SYNC_BYTE, 8'hAA, frame start marker.
- MAX_LEN, 64, largest legal payload length (1..255).
- TIMEOUT_CLKS, 100_000, idle clock cycles allowed between bytes inside a frame before abort.

Ports:
- i_clk  input  1  system clock; the only clock in the block.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  D_BITS  received byte from the UART receiver; valid only when rx_dvalid=1.
- rx_dvalid  input  1  one-cycle pulse per received byte.
- o_data  output  D_BITS  payload byte.
- o_dvalid  output  1  one-cycle pulse per payload byte.
- o_sof  output  1  high with o_dvalid on the first payload byte.
- o_last  output  1  high with o_dvalid on the last payload byte.
- o_frame_ok  output  1  one-cycle pulse: frame checksum matched.
- o_frame_err  output  1  one-cycle pulse: frame aborted.
- o_err_code  output  2  valid with o_frame_err: 01 bad LEN, 10 checksum mismatch, 11 timeout; 00 otherwise.
- o_busy  output  1  high whenever state != IDLE.
- o_err_cnt  output  16  count of o_frame_err pulses; saturates at 16'hFFFF.

Behaviour:
- Clocking and reset: one clock (i_clk); reset is synchronous and active-high.
- Reset values: state=IDLE; all outputs 0; internal sum, length and timeout counters cleared. Reset mid-frame discards the frame and emits no ok/err pulse.
- Output timing: all outputs registered; every response appears the cycle after the rx_dvalid that caused it.
- Pulse widths: o_dvalid, o_sof, o_last, o_frame_ok and o_frame_err are single-cycle; o_err_code returns to 00 when o_frame_err is low.
- FSM IDLE:
  - Byte == SYNC_BYTE -> LEN.
  - Any other byte is silently ignored (sync hunt).
- FSM LEN:
  - Byte == 0 or > MAX_LEN -> err 01, go to IDLE.
  - Otherwise latch remaining count = byte, init sum = byte, go to PAYLOAD.
- FSM PAYLOAD:
  - Each byte is forwarded on o_data/o_dvalid and added to sum (mod 256).
  - o_sof is set on the first payload byte; o_last is set when remaining count hits 1.
  - After the last payload byte -> CHK.
  - A byte equal to SYNC_BYTE inside the payload is data; no resync.
- FSM CHK:
  - Byte == sum[7:0] -> o_frame_ok, go to IDLE.
  - Otherwise -> err 10, go to IDLE.
- LEN=1: the single payload byte carries o_sof=o_last=1.
- Timeout:
  - The counter clears on every rx_dvalid and in IDLE; it increments each cycle while busy without rx_dvalid.
  - When the counter reaches TIMEOUT_CLKS -> err 11, go to IDLE.
  - If the last byte is sampled at edge k, o_frame_err is visible after edge k+TIMEOUT_CLKS.
- Simultaneous events: rx_dvalid in the same cycle the timeout would fire -> the byte wins, the counter clears, and the byte is processed normally.
- Back-to-back frames: a SYNC byte arriving the cycle after CHK is accepted (IDLE is entered the same edge the CHK byte is sampled).
- Error counter: increments on each o_frame_err pulse and holds at 16'hFFFF.
- No backpressure: the downstream consumer must accept one byte per rx_dvalid.
- Sizing: the worst-case byte rate is set by the UART baud, which is far slower than the clock.

Test Plan:
- Good frame: bytes AA 03 11 22 33 69 -> o_dvalid x3 with o_data 11 (o_sof=1), 22, 33 (o_last=1); o_frame_ok pulse after the 69 byte; o_err_cnt=0; o_busy low after.
- Bad checksum: AA 03 11 22 33 68 -> the three payload bytes are still streamed; o_frame_err pulse with o_err_code=10; o_err_cnt=1.
- Bad length: AA 00, then AA 41 with MAX_LEN=64 -> err 01 one cycle after each LEN byte; no o_dvalid; o_err_cnt=2.
- Timeout (TIMEOUT_CLKS=1000): AA 02 11, then silence -> o_frame_err with code 11 exactly 1000 cycles after the 11 byte is sampled. Repeat with a byte injected on cycle 1000 -> no timeout.
- Sync hunt plus LEN=1: 55 00 AA 01 7E 7F -> the first two bytes are ignored; one o_dvalid with o_data 7E, o_sof=o_last=1; o_frame_ok.
- Reset mid-frame: AA 04 01 02, assert reset one cycle -> all outputs 0, o_busy=0, no ok/err pulse. A following good frame AA 01 05 06 passes.
